serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/fulladder_bit.sv | 30 +++
 rtl/halfadder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder_bit.sv
// One-bit full adder built from two half adders, with the carries merged by an OR.
module fulladder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  halfadder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  assign c_o = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// One-bit half adder: sum and carry of two bits.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures operands on START, adds one bit per cycle
// through a single full-adder cell, and presents SUM/COUT with a one-cycle DONE.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic [1:0]       DBG_STATE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: START is accepted on any rising edge where the block is in IDLE or FIN
  // (BUSY=0, or DONE=1); a START seen while adding is dropped, never queued.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s;
  logic             fa_c;

  // The low operand bits always feed the cell; the operand registers shift right.
  fulladder_bit u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ADD;
          cnt_d   = '0;
          a_d     = A_IN;
          b_d     = B_IN;
          carry_d = CIN;
          res_d   = '0;
        end
      end
      S_ADD: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the finished result on the edge that enters FIN.
          state_d = S_FIN;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        if (START) begin
          state_d = S_ADD;
          cnt_d   = '0;
          a_d     = A_IN;
          b_d     = B_IN;
          carry_d = CIN;
          res_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_FIN);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases with literal results plus a random run
// scored every cycle against a timing/arithmetic model of the adder.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int accepts = 0;
  bit chk_en = 0;

  // model: cycles left in the current operation (0 = idle, 1 = result cycle)
  int             m_rem = 0;
  logic [W-1:0]   m_sum = '0;
  logic           m_cout = 1'b0;
  logic [W:0]     exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .A_IN      (a_in),
    .B_IN      (b_in),
    .CIN       (cin),
    .BUSY      (busy),
    .DONE      (done),
    .SUM       (sum),
    .COUT      (cout),
    .DBG_STATE (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: an operation occupies W adding cycles then one result cycle
  always @(posedge clk) begin
    logic [W:0] full;
    if (!rst_n) begin
      m_rem  = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      exp_q.delete();
    end else if (m_rem > 1) begin
      m_rem--;
      if (m_rem == 1) begin
        full   = exp_q.pop_front();
        m_sum  = full[W-1:0];
        m_cout = full[W];
      end
    end else if (start) begin
      full = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, cin};
      exp_q.push_back(full);
      m_rem = W + 1;
      accepts++;
    end else begin
      m_rem = 0;
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, busy}, {63'd0, (m_rem > 0)});
      check("done", {63'd0, done}, {63'd0, (m_rem == 1)});
      check("sum", {56'd0, sum}, {56'd0, m_sum});
      check("cout", {63'd0, cout}, {63'd0, m_cout});
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // wait (bounded) for DONE; lat counts negedges from the first one after the start edge
  task automatic wait_done(output int lat, output int busy_cnt, output bit seen);
    seen = 0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      busy_cnt += int'(busy);
      if (done) begin
        seen = 1;
        lat = i;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] exp);
    int lat;
    int bc;
    bit seen;
    drive_start(a, b, c);
    wait_done(lat, bc, seen);
    check({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({nm, "_latency"}, 64'(lat), 64'(W + 1));
    check({nm, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    check({nm, "_result"}, {55'd0, cout, sum}, {55'd0, exp});
  endtask

  initial begin
    int lat;
    int bc;
    bit seen;
    int last;
    int ndone;
    int gaps_bad;
    int idle_dones;
    int acc0;
    int done0;
    int target;
    int cyc;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum_cout", {55'd0, cout, sum}, 64'd0);
    rst_n = 1'b1;

    // basic additions with hand-computed results
    run_op("add_3c_42", 8'h3C, 8'h42, 1'b0, 9'h07E);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
    run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 9'h100);
    run_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 9'h100);

    // START held high: back-to-back results every W+1 cycles, A_IN wiggled while adding
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h10;
    b_in  = 8'h01;
    cin   = 1'b0;
    last = -1;
    ndone = 0;
    gaps_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_sum", {55'd0, cout, sum}, 64'h11);
        if (last >= 0 && (i - last) != W + 1) gaps_bad++;
        last = i;
        ndone++;
      end
      a_in = (m_rem <= 1) ? 8'h10 : W'($urandom);
    end
    check("b2b_done_count", 64'(ndone), 64'd4);
    check("b2b_gap_errors", 64'(gaps_bad), 64'd0);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // START during ADD with other operands must be ignored
    drive_start(8'h05, 8'h07, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'h55;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, seen);
    check("ignore_done_seen", {63'd0, seen}, 64'd1);
    check("ignore_result", {55'd0, cout, sum}, 64'h00C);

    // reset in the middle of ADD aborts; START under reset ignored
    drive_start(8'h3C, 8'h42, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_sum_cout", {55'd0, cout, sum}, 64'd0);
    idle_dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      idle_dones += int'(done);
    end
    check("abort_no_done", 64'(idle_dones), 64'd0);
    run_op("after_abort", 8'h01, 8'h01, 1'b0, 9'h002);

    // random run: 1000 accepted operations, mixed gaps and back-to-back starts
    @(negedge clk);
    acc0   = accepts;
    done0  = done_cnt;
    target = accepts + 1000;
    cyc    = 0;
    while (accepts < target && cyc < 30000) begin
      start = ($urandom_range(0, 3) != 0);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("rand_accepts", 64'(accepts - acc0), 64'd1000);
    check("rand_done_vs_accepts", 64'(done_cnt - done0), 64'(accepts - acc0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
